// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: 5..9 data bits, none/even/odd/mark parity,
// 1 or 2 stop bits, per-frame baud divisor, and line-break generation.
module uart_tx_cfg #(
   parameter int DATA_W = 8,
   parameter int BAUD_W = 13,
   parameter int LEN_W  = $clog2(DATA_W + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_ready,
   input  logic [BAUD_W-1:0] cfg_baud,
   input  logic [LEN_W-1:0]  cfg_data_bits,
   input  logic [1:0]        cfg_parity,
   input  logic              cfg_stop2,
   input  logic              break_req,
   output logic              busy,
   output logic              frame_done,
   output logic              TX,
   output logic [2:0]        state_dbg
);

   // Handshake: a byte moves on a rising clk edge where tx_valid && tx_ready.
   // tx_ready depends only on state and break_req, never on tx_valid.

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_BREAK  = 3'd5,
      S_MAB    = 3'd6
   } state_e;

   state_e              state_q, state_d;
   logic                tx_q, tx_d;
   logic                done_q, done_d;
   logic [BAUD_W-1:0]   baud_cnt_q, baud_cnt_d;
   logic [BAUD_W-1:0]   baud_l_q, baud_l_d;
   logic [DATA_W-1:0]   shreg_q, shreg_d;
   logic [LEN_W-1:0]    nbits_q, nbits_d;
   logic [LEN_W-1:0]    bit_idx_q, bit_idx_d;
   logic                par_en_q, par_en_d;
   logic                par_bit_q, par_bit_d;
   logic                stop2_q, stop2_d;
   logic                stop_n_q, stop_n_d;

   logic                accept;
   logic                bit_end;
   logic [BAUD_W-1:0]   baud_dec;
   logic [LEN_W-1:0]    n_eff;
   logic [DATA_W-1:0]   data_mask;
   logic                even_par;

   assign tx_ready   = (state_q == S_IDLE) && !break_req;
   assign accept     = tx_valid && tx_ready;
   assign busy       = (state_q != S_IDLE);
   assign frame_done = done_q;
   assign TX         = tx_q;
   assign state_dbg  = state_q;

   assign bit_end  = (baud_cnt_q == '0);
   assign baud_dec = baud_cnt_q - BAUD_W'(1);

   // Out-of-range lengths (0 or above DATA_W) fall back to the full width.
   always_comb begin
      n_eff = cfg_data_bits;
      if (cfg_data_bits == '0 || cfg_data_bits > LEN_W'(DATA_W)) begin
         n_eff = LEN_W'(DATA_W);
      end
   end

   always_comb begin
      data_mask = '0;
      for (int i = 0; i < DATA_W; i++) begin
         data_mask[i] = (LEN_W'(i) < n_eff);
      end
   end

   assign even_par = ^(tx_data & data_mask);

   always_comb begin
      state_d    = state_q;
      tx_d       = tx_q;
      done_d     = 1'b0;
      baud_cnt_d = baud_cnt_q;
      baud_l_d   = baud_l_q;
      shreg_d    = shreg_q;
      nbits_d    = nbits_q;
      bit_idx_d  = bit_idx_q;
      par_en_d   = par_en_q;
      par_bit_d  = par_bit_q;
      stop2_d    = stop2_q;
      stop_n_d   = stop_n_q;

      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (break_req) begin
               state_d = S_BREAK;
               tx_d    = 1'b0;
            end else if (accept) begin
               // Everything the frame needs is captured here; later config edits wait.
               state_d    = S_START;
               tx_d       = 1'b0;
               baud_cnt_d = cfg_baud;
               baud_l_d   = cfg_baud;
               shreg_d    = tx_data;
               nbits_d    = n_eff;
               bit_idx_d  = '0;
               par_en_d   = (cfg_parity != 2'b00);
               stop2_d    = cfg_stop2;
               stop_n_d   = 1'b0;
               case (cfg_parity)
                  2'b10:   par_bit_d = ~even_par;
                  2'b11:   par_bit_d = 1'b1;
                  default: par_bit_d = even_par;
               endcase
            end
         end

         S_START: begin
            if (bit_end) begin
               state_d    = S_DATA;
               tx_d       = shreg_q[0];
               shreg_d    = shreg_q >> 1;
               baud_cnt_d = baud_l_q;
            end else begin
               baud_cnt_d = baud_dec;
            end
         end

         S_DATA: begin
            if (bit_end) begin
               baud_cnt_d = baud_l_q;
               if (bit_idx_q == nbits_q - LEN_W'(1)) begin
                  if (par_en_q) begin
                     state_d = S_PARITY;
                     tx_d    = par_bit_q;
                  end else begin
                     state_d = S_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_idx_d = bit_idx_q + LEN_W'(1);
                  tx_d      = shreg_q[0];
                  shreg_d   = shreg_q >> 1;
               end
            end else begin
               baud_cnt_d = baud_dec;
            end
         end

         S_PARITY: begin
            if (bit_end) begin
               state_d    = S_STOP;
               tx_d       = 1'b1;
               baud_cnt_d = baud_l_q;
            end else begin
               baud_cnt_d = baud_dec;
            end
         end

         S_STOP: begin
            if (bit_end) begin
               if (stop2_q && !stop_n_q) begin
                  stop_n_d   = 1'b1;
                  baud_cnt_d = baud_l_q;
               end else begin
                  state_d = S_IDLE;
                  tx_d    = 1'b1;
                  done_d  = 1'b1;
               end
            end else begin
               baud_cnt_d = baud_dec;
            end
         end

         S_BREAK: begin
            // The mark-after-break uses the live divisor; no frame has latched one.
            if (!break_req) begin
               state_d    = S_MAB;
               tx_d       = 1'b1;
               baud_cnt_d = cfg_baud;
            end else begin
               tx_d = 1'b0;
            end
         end

         S_MAB: begin
            tx_d = 1'b1;
            if (bit_end) begin
               state_d = S_IDLE;
            end else begin
               baud_cnt_d = baud_dec;
            end
         end

         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         tx_q       <= 1'b1;
         done_q     <= 1'b0;
         baud_cnt_q <= '0;
         baud_l_q   <= '0;
         shreg_q    <= '0;
         nbits_q    <= '0;
         bit_idx_q  <= '0;
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
         stop2_q    <= 1'b0;
         stop_n_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_q       <= tx_d;
         done_q     <= done_d;
         baud_cnt_q <= baud_cnt_d;
         baud_l_q   <= baud_l_d;
         shreg_q    <= shreg_d;
         nbits_q    <= nbits_d;
         bit_idx_q  <= bit_idx_d;
         par_en_q   <= par_en_d;
         par_bit_q  <= par_bit_d;
         stop2_q    <= stop2_d;
         stop_n_q   <= stop_n_d;
      end
   end

   a_done_in_idle: assert property (@(posedge clk) disable iff (rst)
      frame_done |-> (state_q == S_IDLE));
   a_break_low: assert property (@(posedge clk) disable iff (rst)
      (state_q == S_BREAK) |-> !TX);

endmodule
